// File: rtl/rr_sel_arb4_pkg.sv
// rtl/rr_sel_arb4_pkg.sv - shared types and constants for the rr_sel_arb4 arbiter
// Purpose: source count, pointer width, FSM state encoding and one-hot select type.
package rr_sel_arb4_pkg;

  localparam int N_SRC = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef logic [N_SRC-1:0] onehot4_t;

  function automatic onehot4_t onehot4(input logic [PTR_W-1:0] idx);
    onehot4 = onehot4_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four requesters
// Purpose: return the first requester at or after ptr (mod 4) not masked by excl.
// Ports:
//   req   in  4  request vector
//   ptr   in  2  highest-priority position
//   excl  in  4  requesters removed from consideration
//   found out 1  a candidate exists
//   idx   out 2  index of the chosen candidate (0 when none)
module rr_pick4
  import rr_sel_arb4_pkg::*;
(
  input  logic     [N_SRC-1:0] req,
  input  logic     [PTR_W-1:0] ptr,
  input  onehot4_t             excl,
  output logic                 found,
  output logic     [PTR_W-1:0] idx
);

  logic [N_SRC-1:0] cand;
  logic [PTR_W-1:0] pos;

  assign cand = req & ~excl;

  // Scan from the farthest position back to ptr so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pos = ptr + PTR_W'(k);
      if (cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arb4.sv
// rtl/rr_sel_arb4.sv - 4-requester round-robin arbiter driving registered one-hot mux selects
// Purpose: grant held until the owner releases, fair rotation on release; all outputs from flops.
// Optional feature: define RR_SEL_ARB4_TIMEOUT_EN for forced handoff after HOLD_MAX grant cycles.
// Ports:
//   CLK    in  1  clock, rising edge
//   RESET  in  1  synchronous active-high reset
//   REQ    in  4  request per source
//   SEL    out 4  one-hot select, 0 when idle
//   GNT_ID out 2  owner index, 0 when idle
//   VALID  out 1  SEL non-zero
//   TMO    out 1  one-cycle pulse on forced handoff (0 without the timeout build)
module rr_sel_arb4
  import rr_sel_arb4_pkg::*;
#(
  parameter int PTR_INIT = 0,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic     [N_SRC-1:0] REQ,
  output onehot4_t             SEL,
  output logic     [PTR_W-1:0] GNT_ID,
  output logic                 VALID,
  output logic                 TMO
);

  if (CNT_W < $clog2(HOLD_MAX + 1) || PTR_INIT < 0 || PTR_INIT > N_SRC - 1) begin : g_bad_cfg
    $error("rr_sel_arb4: illegal PTR_INIT/HOLD_MAX/CNT_W");
  end

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  onehot4_t         sel_nxt;
  logic [PTR_W-1:0] gnt_nxt;
  logic             valid_nxt;
  logic             new_grant;
  logic             owner_req;
  logic             force_ho;
  logic [PTR_W-1:0] pick_ptr;
  onehot4_t         pick_excl;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;

  assign owner_req = REQ[GNT_ID];

  // While granted, the next pick always starts just past the owner.
  assign pick_ptr  = (state == ST_GRANT) ? GNT_ID + PTR_W'(1) : ptr;
  assign pick_excl = force_ho ? onehot4(GNT_ID) : '0;

  rr_pick4 u_pick (
    .req   (REQ),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_SEL_ARB4_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             others_req;

  assign others_req = |(REQ & ~onehot4(GNT_ID));
  // >= so a saturated counter still hands off once a competitor shows up.
  assign force_ho   = (state == ST_GRANT) && owner_req && others_req &&
                      (hold_cnt >= CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt <= '0;
      TMO      <= 1'b0;
    end else begin
      TMO <= force_ho;
      if (new_grant) begin
        hold_cnt <= '0;
      end else if (state == ST_GRANT && hold_cnt != CNT_W'(HOLD_MAX)) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign force_ho = 1'b0;
  assign TMO      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = SEL;
    gnt_nxt   = GNT_ID;
    valid_nxt = VALID;
    new_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) new_grant = 1'b1;
      end
      ST_GRANT: begin
        if (!owner_req || force_ho) begin
          ptr_nxt = pick_ptr;
          if (pick_found) begin
            new_grant = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            sel_nxt   = '0;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (new_grant) begin
      state_nxt = ST_GRANT;
      sel_nxt   = onehot4(pick_idx);
      gnt_nxt   = pick_idx;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      ptr    <= PTR_W'(PTR_INIT);
      SEL    <= '0;
      GNT_ID <= '0;
      VALID  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      SEL    <= sel_nxt;
      GNT_ID <= gnt_nxt;
      VALID  <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_rr_sel_arb4.sv
// tb/tb_rr_sel_arb4.sv - scoreboard bench for rr_sel_arb4 with a behavioural reference model
module tb_rr_sel_arb4;

  localparam int PTR_INIT = 0;
  localparam int HOLD_MAX = 16;
`ifdef RR_SEL_ARB4_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] SEL;
  logic [1:0] GNT_ID;
  logic       VALID;
  logic       TMO;

  rr_sel_arb4 #(
    .PTR_INIT (PTR_INIT),
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (5)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .REQ    (REQ),
    .SEL    (SEL),
    .GNT_ID (GNT_ID),
    .VALID  (VALID),
    .TMO    (TMO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] gnt;
    logic       valid;
    logic       tmo;
    logic       rst;
    logic [3:0] req;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: owner index (-1 = nobody), priority pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = PTR_INIT;
  int m_hold  = 0;
  bit m_tmo   = 1'b0;

  function automatic int pick(input logic [3:0] req, input int ptr, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic rst);
    exp_t e;
    int   others;
    @(negedge CLK);
    REQ   = req;
    RESET = rst;
    m_tmo = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = PTR_INIT;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req, m_ptr, -1);
      m_hold  = 0;
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = pick(req, m_ptr, -1);
      m_hold  = 0;
    end else begin
      others = 0;
      for (int i = 0; i < 4; i++) if (req[i] && i != m_owner) others = 1;
      if (TMO_EN && others != 0 && m_hold >= HOLD_MAX - 1) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = pick(req, m_ptr, m_owner);
        m_hold  = 0;
        m_tmo   = 1'b1;
      end else if (m_hold < HOLD_MAX) begin
        m_hold++;
      end
    end
    e.sel   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.gnt   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.valid = (m_owner >= 0);
    e.tmo   = m_tmo;
    e.rst   = rst;
    e.req   = req;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  initial begin
    int   waits[4];
    int   prev;
    int   cur;
    exp_t e;
    prev = -1;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sel", SEL, e.sel);
        chk("gnt_id", GNT_ID, e.gnt);
        chk("valid", VALID, e.valid);
        chk("tmo", TMO, e.tmo);
        chk("sel_onehot0", $onehot0(SEL), 1);
        chk("valid_is_or_sel", VALID, |SEL);
        cur = VALID ? int'(GNT_ID) : -1;
        if (e.rst) begin
          for (int i = 0; i < 4; i++) waits[i] = 0;
          prev = -1;
        end else begin
          for (int i = 0; i < 4; i++) if (!e.req[i]) waits[i] = 0;
          if (prev >= 0 && cur != prev)
            for (int i = 0; i < 4; i++) if (e.req[i] && i != cur) waits[i]++;
          if (cur >= 0 && cur != prev) begin
            chk("fair_releases_le3", int'(waits[cur] <= 3), 1);
            waits[cur] = 0;
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);
    // First grant with PTR_INIT=0, then direct handoff skipping 0.
    drive(4'b1010, 1'b0);
    drive(4'b1010, 1'b0);
    drive(4'b1001, 1'b0);
    drive(4'b1001, 1'b0);
    // Release to idle, pointer wraps to 0.
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    // Owner 0 drops with 2 waiting, then reset mid-grant.
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    drive(4'b1111, 1'b0);
    // Long hold with a competitor, then long hold alone.
    for (int k = 0; k < 22; k++) drive(4'b0011, 1'b0);
    drive(4'b0000, 1'b0);
    for (int k = 0; k < 22; k++) drive(4'b0001, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0000, 1'b0);
    // Randomised traffic: requests held until served, owner releases at random.
    r = 4'b0000;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == m_owner) begin
          if ($urandom_range(3) == 0) r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(2) == 0) begin
          r[i] = 1'b1;
        end
      end
      drive(r, $urandom_range(299) == 0);
    end
    drive(4'b0000, 1'b0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
